// File: rtl/cpld_spi_responder.sv
// SPI mode-0 register responder oversampled by sysclk: ID, status, control and scratch bytes.
// Optional CPLD_SPI_WRITE_EN enables commits to the control (0x02) and scratch (0x03) registers.
module cpld_spi_responder #(
  parameter logic [7:0] ID_VALUE   = 8'hA5,
  parameter logic [7:0] CTRL_RESET = 8'h00
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_INV,
  output logic       spi_miso,
  input  logic [7:0] status_in,
  output logic [7:0] ctrl_out,
  output logic       ctrl_wr,
  output logic       frame_err
);

`ifdef CPLD_SPI_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e      state_q;
  logic [2:0]  clk_sync_q, cs_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [1:0]  fill_q;
  logic        armed_q;
  logic [3:0]  cnt_q;
  logic [6:0]  rx_q;
  logic        wr_q;
  logic [6:0]  addr_q;
  logic [7:0]  snap_q;
  logic        miso_q;
  logic [7:0]  ctrl_q, scratch_q;
  logic        ctrl_wr_q, frame_err_q;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  assign sclk_rise = clk_sync_q[1] & ~clk_sync_q[2];
  assign sclk_fall = ~clk_sync_q[1] & clk_sync_q[2];
  // CS fall only counts once the synchronizer has really seen the pin high,
  // so a CS still low across reset cannot open a frame.
  assign cs_fall   = armed_q & cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  function automatic logic [7:0] read_mux(input logic [6:0] a);
    case (a)
      7'h00:   read_mux = ID_VALUE;
      7'h01:   read_mux = status_in;
      7'h02:   read_mux = ctrl_q;
      7'h03:   read_mux = scratch_q;
      default: read_mux = 8'h00;
    endcase
  endfunction

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_sync_q  <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      fill_q      <= 2'b00;
      armed_q     <= 1'b0;
      cnt_q       <= 4'd0;
      rx_q        <= 7'd0;
      wr_q        <= 1'b0;
      addr_q      <= 7'd0;
      snap_q      <= 8'd0;
      miso_q      <= 1'b0;
      ctrl_q      <= CTRL_RESET;
      scratch_q   <= 8'h00;
      ctrl_wr_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_INV};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      fill_q      <= {fill_q[0], 1'b1};
      if (fill_q[1] && cs_sync_q[1]) armed_q <= 1'b1;
      ctrl_wr_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q <= SHIFT;
            cnt_q   <= 4'd0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            miso_q      <= 1'b0;
          end else if (sclk_rise) begin
            rx_q  <= {rx_q[5:0], mosi_s};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              // header complete: latch W/address and freeze the read data
              wr_q   <= rx_q[6];
              addr_q <= {rx_q[5:0], mosi_s};
              snap_q <= read_mux({rx_q[5:0], mosi_s});
            end
            if (cnt_q == 4'd15) begin
              state_q <= DONE;
              miso_q  <= 1'b0;
              if (WR_EN && wr_q) begin
                if (addr_q == 7'h02) begin
                  ctrl_q    <= {rx_q[6:0], mosi_s};
                  ctrl_wr_q <= 1'b1;
                end else if (addr_q == 7'h03) begin
                  scratch_q <= {rx_q[6:0], mosi_s};
                end
              end
            end
          end else if (sclk_fall && cnt_q >= 4'd8 && !wr_q) begin
            miso_q <= snap_q[7];
            snap_q <= {snap_q[6:0], 1'b0};
          end
        end
        DONE: begin
          miso_q <= 1'b0;
          if (cs_rise) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso  = miso_q;
  assign ctrl_out  = ctrl_q;
  assign ctrl_wr   = ctrl_wr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cpld_spi_responder.sv
// Bench for cpld_spi_responder: directed plus random SPI frames against a register-map model.
module tb_cpld_spi_responder;

`ifdef CPLD_SPI_WRITE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       reset, spi_clk, spi_mosi, spi_cs_INV, spi_miso;
  logic [7:0] status_in, ctrl_out;
  logic       ctrl_wr, frame_err;

  int n_vec = 0, n_bad = 0;
  int n_wr = 0, n_err = 0;
  logic [7:0] ctrl_m = 8'h00, scratch_m = 8'h00;

  cpld_spi_responder dut (
    .sysclk(sysclk), .reset(reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_cs_INV(spi_cs_INV), .spi_miso(spi_miso), .status_in(status_in),
    .ctrl_out(ctrl_out), .ctrl_wr(ctrl_wr), .frame_err(frame_err)
  );

  always #5 sysclk = ~sysclk;

  // pulse-cycle counters; a stretched pulse shows up as a count > 1
  always @(negedge sysclk) begin
    if (ctrl_wr)   n_wr  <= n_wr + 1;
    if (frame_err) n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [6:0] a, input logic [7:0] st);
    case (a)
      7'h00:   return 8'hA5;
      7'h01:   return st;
      7'h02:   return ctrl_m;
      7'h03:   return scratch_m;
      default: return 8'h00;
    endcase
  endfunction

  // host side of one frame; MISO captured at each SCLK rise, MSB first
  task automatic spi_xfer(input logic [15:0] word, input int nbits, input bit chg,
                          input int rst_bit, output logic [31:0] rx);
    rx = '0;
    spi_cs_INV = 1'b0;
    repeat (5) @(negedge sysclk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? word[15-i] : 1'($urandom_range(0, 1));
      repeat (6) @(negedge sysclk);
      spi_clk = 1'b1;
      rx = {rx[30:0], spi_miso};
      if (i == rst_bit) begin
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
      end
      repeat (6) @(negedge sysclk);
      if (chg && i == 7) status_in = ~status_in;
      spi_clk = 1'b0;
    end
    repeat (6) @(negedge sysclk);
    spi_cs_INV = 1'b1;
    repeat (10) @(negedge sysclk);
  endtask

  task automatic do_frame(input string tag, input logic [15:0] word, input int nbits,
                          input bit chg, input int rst_bit);
    logic [31:0] rx, frm, extra;
    logic [7:0]  st;
    logic        w;
    logic [6:0]  a;
    int          wr0, err0, exp_wr, exp_err;
    st = status_in; wr0 = n_wr; err0 = n_err;
    w = word[15]; a = word[14:8];
    spi_xfer(word, nbits, chg, rst_bit, rx);
    exp_wr = 0; exp_err = 0;
    if (rst_bit >= 0) begin
      ctrl_m = 8'h00; scratch_m = 8'h00;
    end else if (nbits < 16) begin
      exp_err = 1;
    end else begin
      frm = rx >> (nbits - 16);
      chk({tag, "_miso"}, {16'h0, frm[15:0]}, w ? 32'h0 : {24'h0, exp_read(a, st)});
      if (nbits > 16) begin
        extra = rx & ((32'h1 << (nbits - 16)) - 32'h1);
        chk({tag, "_tail"}, extra, 32'h0);
      end
      if (w && WEN) begin
        if (a == 7'h02) begin ctrl_m = word[7:0]; exp_wr = 1; end
        else if (a == 7'h03) scratch_m = word[7:0];
      end
    end
    chk({tag, "_ctrl"}, {24'h0, ctrl_out}, {24'h0, ctrl_m});
    chk({tag, "_wr"}, n_wr - wr0, exp_wr);
    chk({tag, "_err"}, n_err - err0, exp_err);
  endtask

  initial begin
    logic [15:0] word;
    int          nb, r;
    reset = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_INV = 1'b1; status_in = 8'h00;
    repeat (5) @(negedge sysclk);
    chk("rst_miso", {31'h0, spi_miso}, 32'h0);
    chk("rst_ctrl", {24'h0, ctrl_out}, 32'h0);
    chk("rst_wr", {31'h0, ctrl_wr}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge sysclk);

    do_frame("rd_id", 16'h0000, 16, 1'b0, -1);
    status_in = 8'h3C;
    do_frame("rd_stat", 16'h0100, 16, 1'b1, -1);
    do_frame("wr_ctrl", 16'h825A, 16, 1'b0, -1);
    do_frame("rd_ctrl", 16'h0200, 16, 1'b0, -1);
    do_frame("wr_abort", 16'h8377, 10, 1'b0, -1);
    do_frame("rd_scr0", 16'h0300, 16, 1'b0, -1);
    do_frame("wr_scr", 16'h8342, 16, 1'b0, -1);
    do_frame("rd_scr1", 16'h0300, 16, 1'b0, -1);
    do_frame("rst_mid", 16'h82FF, 16, 1'b0, 12);
    do_frame("rd_ctrl2", 16'h0200, 16, 1'b0, -1);
    do_frame("rd_scr2", 16'h0300, 16, 1'b0, -1);
    do_frame("long24", 16'h0000, 24, 1'b0, -1);
    do_frame("after24", 16'h0100, 16, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      status_in = 8'($urandom);
      word = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 5)), 8'($urandom)};
      r = $urandom_range(0, 9);
      nb = (r < 7) ? 16 : (r == 7) ? 24 : $urandom_range(2, 15);
      do_frame("rnd", word, nb, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
